mem_arbiter: RTL

Three-requester arbiter that shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between the core's instruction-fetch port, the core's data port and a DMA/loader port. It sits between `rvcpu` and the unified program/data RAM. It issues at most one RAM access per cycle and routes read data back to the owner one cycle later. Fairness is round-robin, and the DMA port may hold a bounded burst lock.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_pick3.sv | 38 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-port RAM arbiter.
// Port IDs double as round-robin positions (IF -> D -> X -> IF).
// The lock FSM encoding and the default DMA burst limit are also defined here.
package mem_arb_pkg;

    localparam logic [1:0] PORT_IF = 2'd0;
    localparam logic [1:0] PORT_D  = 2'd1;
    localparam logic [1:0] PORT_X  = 2'd2;

    localparam int LOCK_MAX_DEF = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Encode a one-hot {x, d, if} grant vector as a port ID. IF is returned when nothing is set.
    function automatic logic [1:0] port_of(input logic [2:0] onehot);
        logic [1:0] p;
        p = PORT_IF;
        if (onehot[PORT_D]) p = PORT_D;
        if (onehot[PORT_X]) p = PORT_X;
        return p;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker. Search starts at the port after 'last'.
// Latency: 0 cycles. Backpressure: none; a request that is not picked simply waits.
// Ports: req[2:0] {x,d,if}, last = most recently granted port, force_x gives X absolute priority, gnt = one-hot pick.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       force_x,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (force_x && req[PORT_X]) begin
            gnt[PORT_X] = 1'b1;
        end else begin
            case (last)
                PORT_IF: begin
                    if      (req[PORT_D])  gnt[PORT_D]  = 1'b1;
                    else if (req[PORT_X])  gnt[PORT_X]  = 1'b1;
                    else if (req[PORT_IF]) gnt[PORT_IF] = 1'b1;
                end
                PORT_D: begin
                    if      (req[PORT_X])  gnt[PORT_X]  = 1'b1;
                    else if (req[PORT_IF]) gnt[PORT_IF] = 1'b1;
                    else if (req[PORT_D])  gnt[PORT_D]  = 1'b1;
                end
                default: begin
                    if      (req[PORT_IF]) gnt[PORT_IF] = 1'b1;
                    else if (req[PORT_D])  gnt[PORT_D]  = 1'b1;
                    else if (req[PORT_X])  gnt[PORT_X]  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port sync RAM between instruction fetch (if_*), data (d_*) and DMA (x_*) ports.
// Latency: req->gnt 0 cycles (combinational); gnt->rvalid 1 cycle; at most one RAM access per cycle.
// Backpressure: a requester holds its request until it sees gnt. Round-robin order is IF->D->X. DMA may lock for up to LOCK_MAX grants.
// RAM side: mem_en/mem_addr/mem_we/mem_d are muxed from the granted port. mem_q returns the read one cycle later and is steered to the owner via rdata + *_rvalid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    input  logic        x_req,
    input  logic [31:0] x_addr,
    input  logic [3:0]  x_we,
    input  logic [31:0] x_wdata,
    output logic        x_gnt,
    output logic        x_rvalid,
    input  logic        x_lock,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_q
);

    localparam logic [4:0] LOCK_MAX_C = 5'(LOCK_MAX);

    lock_state_t lock_state;
    logic [4:0]  lock_cnt;
    logic [1:0]  last;
    logic        tag_vld;
    logic [1:0]  tag_port;

    logic [2:0]  gnt;
    logic [1:0]  gnt_port;
    logic        gnt_rd;

    // Byte offsets are dropped: the RAM is word addressed and lanes are selected by we.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0], x_addr[1:0]};

    rr_pick3 u_pick (
        .req     ({x_req, d_req, if_req}),
        .last    (last),
        .force_x (lock_state == LOCKED),
        .gnt     (gnt)
    );

    assign if_gnt   = gnt[PORT_IF];
    assign d_gnt    = gnt[PORT_D];
    assign x_gnt    = gnt[PORT_X];
    assign gnt_port = port_of(gnt);

    always_comb begin
        mem_en   = |gnt;
        mem_addr = 32'h0;
        mem_we   = 4'h0;
        mem_d    = 32'h0;
        if (gnt[PORT_IF]) begin
            mem_addr = {if_addr[31:2], 2'b00};
        end else if (gnt[PORT_D]) begin
            mem_addr = {d_addr[31:2], 2'b00};
            mem_we   = d_we;
            mem_d    = d_wdata;
        end else if (gnt[PORT_X]) begin
            mem_addr = {x_addr[31:2], 2'b00};
            mem_we   = x_we;
            mem_d    = x_wdata;
        end
    end

    assign gnt_rd = mem_en && (mem_we == 4'h0);

    // Read return steering: the tag only ever holds a valid port ID, so tag_vld alone qualifies rdata.
    assign if_rvalid = tag_vld && (tag_port == PORT_IF);
    assign d_rvalid  = tag_vld && (tag_port == PORT_D);
    assign x_rvalid  = tag_vld && (tag_port == PORT_X);
    assign rdata     = tag_vld ? mem_q : 32'h0;

    // Arbitration history and owner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= PORT_X;
            tag_vld  <= 1'b0;
            tag_port <= PORT_IF;
        end else begin
            if (mem_en) last <= gnt_port;
            tag_vld  <= gnt_rd;
            tag_port <= gnt_port;
        end
    end

    // DMA burst lock. A forced release always coincides with an X grant, so 'last'
    // becomes X and the lock can only be retaken through a normal round-robin X grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= UNLOCKED;
            lock_cnt   <= 5'd0;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (gnt[PORT_X] && x_lock && (LOCK_MAX_C > 5'd1)) begin
                        lock_state <= LOCKED;
                        lock_cnt   <= 5'd1;
                    end
                end
                LOCKED: begin
                    if (!x_lock || !x_req ||
                        (gnt[PORT_X] && (lock_cnt + 5'd1 == LOCK_MAX_C))) begin
                        lock_state <= UNLOCKED;
                        lock_cnt   <= 5'd0;
                    end else if (gnt[PORT_X]) begin
                        lock_cnt <= lock_cnt + 5'd1;
                    end
                end
                default: begin
                    lock_state <= UNLOCKED;
                    lock_cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule
